// File: rtl/sequential_divider_pkg.sv
// ============================================================================
// Module      : sequential_divider_pkg
// Description : Shared widths, iteration count and FSM state encoding for the
//               8-by-4 restoring sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sequential_divider_pkg;

    localparam int DIVIDEND_W  = 8;
    localparam int DIVISOR_W   = 4;
    localparam int QUOTIENT_W  = 8;
    localparam int REMAINDER_W = 4;
    localparam int PARTIAL_W   = 5;
    localparam int ITER_COUNT  = 8;
    localparam int CNT_W       = $clog2(ITER_COUNT);

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : sequential_divider_pkg

`default_nettype wire

// File: rtl/sequential_divider_if.sv
// ============================================================================
// Module      : sequential_divider_if
// Description : Request/result bundle between a requester and the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sequential_divider_if
    import sequential_divider_pkg::*;
();

    logic                   start;
    logic [DIVIDEND_W-1:0]  dividend;
    logic [DIVISOR_W-1:0]   divisor;
    logic                   busy;
    logic                   done;
    logic [QUOTIENT_W-1:0]  quotient;
    logic [REMAINDER_W-1:0] remainder;
    logic                   div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : sequential_divider_if

`default_nettype wire

// File: rtl/sequential_divider_div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import sequential_divider_pkg::*;
(
    input  wire logic [PARTIAL_W-1:0] rem_in,
    input  wire logic                 next_bit,
    input  wire logic [DIVISOR_W-1:0] divisor,
    output logic      [PARTIAL_W-1:0] rem_out,
    output logic                      q_bit
);

    // One extra bit of headroom keeps the compare exact for any rem_in.
    logic [PARTIAL_W:0] w_shifted;

    always_comb begin
        w_shifted = {rem_in, next_bit};
        q_bit     = (w_shifted >= {2'b00, divisor});
        rem_out   = q_bit ? PARTIAL_W'(w_shifted - {2'b00, divisor})
                          : w_shifted[PARTIAL_W-1:0];
    end

endmodule : div_step

`default_nettype wire

// File: rtl/sequential_divider.sv
// ============================================================================
// Module      : sequential_divider
// Description : 8-bit by 4-bit unsigned restoring divider, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequential_divider
    import sequential_divider_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    sequential_divider_if.slave   bus
);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]       r_iter_cnt;
    logic [PARTIAL_W-1:0]   r_partial;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [DIVIDEND_W-1:0]  r_dvd_shift;
    logic [DIVISOR_W-1:0]   r_divisor;
    logic [QUOTIENT_W-1:0]  r_quotient;
    logic [REMAINDER_W-1:0] r_remainder;
    logic                   r_div_by_zero;

    logic                   w_accept;
    logic                   w_last_iter;
    logic                   w_divisor_zero;
    logic [PARTIAL_W-1:0]   w_step_rem;
    logic                   w_step_q;

    div_step u_div_step (
        .rem_in   (r_partial),
        .next_bit (r_dvd_shift[DIVIDEND_W-1]),
        .divisor  (r_divisor),
        .rem_out  (w_step_rem),
        .q_bit    (w_step_q)
    );

    assign w_divisor_zero = (bus.divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last_iter  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_divisor_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_iter_cnt == ITER_LAST) begin
                    w_last_iter  = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter_cnt    <= '0;
            r_partial     <= '0;
            r_dvd_shift   <= '0;
            r_divisor     <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_iter_cnt  <= '0;
            r_partial   <= '0;
            r_dvd_shift <= bus.dividend;
            r_divisor   <= bus.divisor;
            // A zero divisor completes immediately with the saturated result.
            if (w_divisor_zero) begin
                r_quotient    <= '1;
                r_remainder   <= '0;
                r_div_by_zero <= 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            r_iter_cnt  <= r_iter_cnt + CNT_W'(1);
            r_partial   <= w_step_rem;
            r_dvd_shift <= {r_dvd_shift[DIVIDEND_W-2:0], w_step_q};
            if (w_last_iter) begin
                r_quotient    <= {r_dvd_shift[DIVIDEND_W-2:0], w_step_q};
                r_remainder   <= w_step_rem[REMAINDER_W-1:0];
                r_div_by_zero <= 1'b0;
            end
        end
    end

    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule : sequential_divider

`default_nettype wire

// File: tb/tb_sequential_divider.sv
// ============================================================================
// Module      : tb_sequential_divider
// Description : Scoreboard bench for sequential_divider: directed cases, reset
//               abandonment, start-while-busy and an exhaustive operand sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequential_divider;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        int         acc_cyc;
    } req_t;

    logic clk;
    logic rst_n;
    int   vec_cnt  = 0;
    int   err_cnt  = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   last_q   = 0;
    int   last_r   = 0;
    int   last_z   = 0;
    req_t exp_q[$];

    sequential_divider_if bus ();

    sequential_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Waits for IDLE, drives one request and queues its expected outcome.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", int'(n < 100), 1);
        exp_q.push_back('{a: a, b: b, acc_cyc: cyc + 1});
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Result monitor: compares against an arithmetic reference, not the RTL.
    always @(negedge clk) begin
        req_t e;
        int   eq, er, ez;
        if (!rst_n) begin
            busy_cnt = 0;
            last_q   = 0;
            last_r   = 0;
            last_z   = 0;
        end else begin
            if (bus.busy) begin
                busy_cnt++;
                check("hold_quotient", bus.quotient, last_q);
                check("hold_remainder", bus.remainder, last_r);
            end
            if (bus.done) begin
                done_cnt++;
                check("done_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e  = exp_q.pop_front();
                    eq = (e.b == 0) ? 255 : int'(e.a) / int'(e.b);
                    er = (e.b == 0) ? 0   : int'(e.a) % int'(e.b);
                    ez = (e.b == 0) ? 1   : 0;
                    check($sformatf("quotient %0d/%0d", e.a, e.b), bus.quotient, eq);
                    check($sformatf("remainder %0d/%0d", e.a, e.b), bus.remainder, er);
                    check($sformatf("div_by_zero %0d/%0d", e.a, e.b), bus.div_by_zero, ez);
                    check($sformatf("latency %0d/%0d", e.a, e.b), cyc - e.acc_cyc, (e.b == 0) ? 0 : 8);
                    check($sformatf("busy_cycles %0d/%0d", e.a, e.b), busy_cnt, (e.b == 0) ? 0 : 8);
                    if (e.b != 0) begin
                        check("invariant", int'(bus.quotient) * int'(e.b) + int'(bus.remainder), int'(e.a));
                        check("rem_lt_div", int'(bus.remainder < e.b), 1);
                    end
                    last_q = eq;
                    last_r = er;
                    last_z = ez;
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int snap;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_div_by_zero", bus.div_by_zero, 0);

        // Release just after an edge so the next edge is the first with rst_n=1.
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(8'd100, 4'd7);
        issue(8'd255, 4'd1);
        issue(8'd3,   4'd15);
        issue(8'd200, 4'd0);
        issue(8'd9,   4'd3);
        drain();

        // Start pulse and operand churn while busy must be ignored.
        snap = done_cnt;
        issue(8'd50, 4'd5);
        repeat (2) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd99;
        bus.divisor  = 4'd9;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 8'hAA;
        bus.divisor  = 4'd3;
        drain();
        repeat (12) @(negedge clk);
        check("single_done", done_cnt - snap, 1);

        // Reset mid-run: outputs clear at once and no completion follows.
        issue(8'd77, 4'd4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        check("midrst_div_by_zero", bus.div_by_zero, 0);
        exp_q.delete();
        snap = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_reset", done_cnt - snap, 0);
        issue(8'd77, 4'd4);
        drain();

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(8'(a), 4'(b));
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_sequential_divider

`default_nettype wire

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 Parameters: none; widths fixed at dividend 8, divisor 4, quotient 8, remainder 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned numerator; sampled with accepted start.
REQ-006 divisor  input  4  unsigned denominator; sampled with accepted start.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 quotient  output  8  unsigned result; held until the next completion.
REQ-010 remainder  output  4  unsigned result; held until the next completion.
REQ-011 div_by_zero  output  1  error flag for the last operation; held with results.

Function
REQ-012 FSM states shall be IDLE, RUN and DONE, with one-hot or binary encoding taken from the shared package.
REQ-013 IDLE with start=1 at an edge: latch operands; go to RUN if divisor!=0, else go to DONE with the zero flag set.
REQ-014 RUN shall execute exactly 8 restoring iterations, one per edge, MSB of dividend first, using a 5-bit partial remainder and a 3-bit iteration counter.
REQ-015 Each iteration: shift the partial remainder left, shifting in the next dividend bit; if it is >= divisor, subtract the divisor and set quotient bit 1, else set quotient bit 0.
REQ-016 On the 8th iteration edge (counter=7), go to DONE and load quotient/remainder output registers.
REQ-017 DONE lasts exactly one cycle (done=1), then returns to IDLE unconditionally.
REQ-018 Latency: done is high in the cycle following the 8th edge after the start-sampling edge (9 cycles start-to-done).
REQ-019 Divide by zero: done is high in the cycle after the start-sampling edge; quotient=8'hFF, remainder=4'h0, div_by_zero=1.
REQ-020 div_by_zero shall clear on the next completion of a nonzero-divisor operation.
REQ-021 start in RUN or DONE shall be ignored, with no queuing; start held high from DONE is accepted in the following IDLE cycle.
REQ-022 Operand input changes during RUN shall not affect the result.
REQ-023 Outputs shall keep the previous result during RUN; no intermediate values shall be visible.
REQ-024 The invariant quotient*divisor + remainder == dividend, with remainder < divisor, shall hold for every nonzero divisor.

Reset
REQ-025 rst_n=0 shall immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, with counter and datapath cleared.
REQ-026 Reset during RUN shall abandon the operation, with no done pulse after release.
REQ-027 The first start after rst_n deasserts shall be accepted at the first rising edge where rst_n=1.

Structure
REQ-028 The shared header shall hold state encodings, widths (8/4/5) and ITER_COUNT=8.
REQ-029 One combinational sub-module, div_step, shall compute one restoring step: inputs are partial remainder, next bit and divisor; outputs are new remainder and quotient bit.
REQ-030 The FSM, counter and registers shall stay in sequential_divider, which instantiates div_step once.

Verification
REQ-031 Dividend 100, divisor 7 -> quotient 14, remainder 2, done exactly 9 cycles after start, busy high for 8 cycles.
REQ-032 Dividend 255, divisor 1 -> quotient 255, remainder 0; then dividend 3, divisor 15 -> quotient 0, remainder 3.
REQ-033 Dividend 200, divisor 0 -> done after 1 cycle, quotient 8'hFF, remainder 0, div_by_zero=1; then 9/3 -> quotient 3, remainder 0, div_by_zero=0.
REQ-034 Start 50/5, pulse start with 99/9 during RUN -> single done, quotient 10, remainder 0; operand changes mid-RUN have no effect.
REQ-035 Start 77/4, assert rst_n=0 at iteration 4 -> outputs zero immediately, no done after release; a new 77/4 run gives quotient 19, remainder 1.
REQ-036 Exhaustive sweep of all 8x4-bit operand pairs checked against a reference model for REQ-024, with back-to-back starts.
